// File: rtl/uart_alu_intf.sv
// Byte-to-command bridge between a uart and a combinational ALU: collects A, B and opcode,
// returns the ALU result through the transmitter. Optional inter-byte timeout: UART_ALU_TIMEOUT_EN.
module uart_alu_intf #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_timeout
);

    typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;

    state_t             state, state_nxt;
    logic [NB_DATA-1:0] alu_a_nxt, alu_b_nxt, tx_data_nxt;
    logic [NB_OP-1:0]   alu_op_nxt;
    logic               tx_start_nxt, busy_nxt, timeout_nxt;
    logic               expire;

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // Counter only runs while waiting for the next byte of a partial command
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            cnt <= '0;
        else if (i_rx_done || !(state == WAIT_B || state == WAIT_OP))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign expire = (state == WAIT_B || state == WAIT_OP) && !i_rx_done &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_alu_a    <= alu_a_nxt;
            o_alu_b    <= alu_b_nxt;
            o_alu_op   <= alu_op_nxt;
            o_tx_data  <= tx_data_nxt;
            o_tx_start <= tx_start_nxt;
            o_busy     <= busy_nxt;
            o_timeout  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_rx_done) state_nxt = WAIT_B;
            WAIT_B:  if (i_rx_done) state_nxt = WAIT_OP; else if (expire) state_nxt = IDLE;
            WAIT_OP: if (i_rx_done) state_nxt = EXEC;    else if (expire) state_nxt = IDLE;
            EXEC:    state_nxt = SEND;
            SEND:    state_nxt = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so that every port is a flop
    always_comb begin
        alu_a_nxt    = (state == IDLE    && i_rx_done) ? i_rx_data : o_alu_a;
        alu_b_nxt    = (state == WAIT_B  && i_rx_done) ? i_rx_data : o_alu_b;
        alu_op_nxt   = (state == WAIT_OP && i_rx_done) ? i_rx_data[NB_OP-1:0] : o_alu_op;
        tx_data_nxt  = (state == EXEC) ? i_alu_result : o_tx_data;
        tx_start_nxt = (state == EXEC);
        busy_nxt     = (state_nxt == EXEC) || (state_nxt == SEND) || (state_nxt == WAIT_TX);
        timeout_nxt  = expire;
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed and randomized bench for uart_alu_intf with a small ALU and a command-level reference.
module tb_uart_alu_intf;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [7:0] o_alu_a, o_alu_b, o_tx_data;
    logic [5:0] o_alu_op;
    logic       o_tx_start, o_busy, o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int to_cnt    = 0;
    int exp_starts = 0;
    logic [7:0] last_a;

    uart_alu_intf #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    assign i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

    always @(posedge clk) begin
        if (i_reset) begin
            if (o_tx_start) start_cnt <= start_cnt + 1;
            if (o_timeout)  to_cnt    <= to_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    // Sends a full command and checks the exact result timing; ends in WAIT_TX
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int gap, input bit tx_done_in_send);
        logic [7:0] exp_res;
        exp_res = alu_f(a, b, opb[5:0]);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        send_byte(opb);
        chk("exec_busy", o_busy, 1);
        chk("exec_nostart", o_tx_start, 0);
        tick();
        chk("start_high", o_tx_start, 1);
        chk("tx_data", o_tx_data, exp_res);
        chk("alu_a", o_alu_a, a);
        chk("alu_b", o_alu_b, b);
        chk("alu_op", o_alu_op, opb[5:0]);
        i_tx_done = tx_done_in_send;
        tick();
        i_tx_done = 1'b0;
        chk("start_low", o_tx_start, 0);
        exp_starts++;
        last_a = a;
    endtask

    task automatic finish_cmd(input int wait_n);
        idle(wait_n);
        chk("wait_busy", o_busy, 1);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("done_idle", o_busy, 0);
        chk("start_count", start_cnt, exp_starts);
    endtask

    initial begin
        logic [7:0] ra, rb, rop;
        i_reset   = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        last_a    = 8'h00;
        idle(2);
        chk("rst_a", o_alu_a, 0);
        chk("rst_b", o_alu_b, 0);
        chk("rst_op", o_alu_op, 0);
        chk("rst_txd", o_tx_data, 0);
        chk("rst_start", o_tx_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_timeout", o_timeout, 0);
        i_reset = 1'b1;
        idle(2);

        // Basic add command, then a second command right after
        issue(8'h05, 8'h03, 8'h20, 1, 1'b0);
        finish_cmd(3);
        issue(8'h09, 8'h04, 8'h22, 0, 1'b0);
        finish_cmd(0);

        // Asynchronous reset in the middle of a partial command
        send_byte(8'h11);
        send_byte(8'h22);
        i_reset = 1'b0;
        #2;
        chk("arst_a", o_alu_a, 0);
        chk("arst_b", o_alu_b, 0);
        chk("arst_op", o_alu_op, 0);
        chk("arst_txd", o_tx_data, 0);
        chk("arst_busy", o_busy, 0);
        tick();
        i_reset = 1'b1;
        tick();
        issue(8'h01, 8'h01, 8'h20, 0, 1'b0);
        finish_cmd(1);

        // Opcode truncation
        issue(8'h30, 8'h10, 8'hE2, 2, 1'b0);
        finish_cmd(1);

        // Extra byte during WAIT_TX is dropped
        issue(8'h07, 8'h01, 8'h20, 0, 1'b0);
        send_byte(8'h7F);
        idle(3);
        chk("extra_busy", o_busy, 1);
        chk("extra_a", o_alu_a, 8'h07);
        chk("extra_starts", start_cnt, exp_starts);
        finish_cmd(0);
        issue(8'h04, 8'h02, 8'h22, 0, 1'b0);
        finish_cmd(2);

        // tx_done in IDLE and in SEND is ignored
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("txdone_idle_busy", o_busy, 0);
        issue(8'hF0, 8'h0F, 8'h25, 1, 1'b1);
        idle(2);
        chk("txdone_send_busy", o_busy, 1);
        chk("txdone_send_starts", start_cnt, exp_starts);
        finish_cmd(0);

        // rx_done and tx_done together in WAIT_TX: finish, byte discarded
        issue(8'h3C, 8'h5A, 8'h26, 0, 1'b0);
        i_rx_data = 8'h55;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        chk("both_idle", o_busy, 0);
        issue(8'h10, 8'h20, 8'h24, 0, 1'b0);
        finish_cmd(0);

        // Randomized commands with random inter-byte gaps
        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            case ($urandom_range(0, 5))
                0: rop = 8'h20;
                1: rop = 8'h22;
                2: rop = 8'h24;
                3: rop = 8'h25;
                4: rop = 8'h26;
                default: rop = 8'($urandom);
            endcase
            rop[7:6] = 2'($urandom);
            issue(ra, rb, rop, $urandom_range(0, 3), 1'($urandom));
            finish_cmd($urandom_range(0, 4));
        end

        // Inter-byte timeout (only fires when the feature is compiled in)
        to_cnt = 0;
        send_byte(8'h09);
        idle(99);
        chk("to_before", o_timeout, 0);
        tick();
`ifdef UART_ALU_TIMEOUT_EN
        chk("to_pulse", o_timeout, 1);
        tick();
        chk("to_after", o_timeout, 0);
        chk("to_count", to_cnt, 1);
        chk("to_keep_a", o_alu_a, 8'h09);
        issue(8'h02, 8'h03, 8'h20, 0, 1'b0);
        finish_cmd(0);
`else
        chk("to_never", o_timeout, 0);
        tick();
        chk("to_count", to_cnt, 0);
        send_byte(8'h02);
        send_byte(8'h03);
        tick();
        chk("nto_start", o_tx_start, 1);
        chk("nto_data", o_tx_data, alu_f(8'h09, 8'h02, 6'h03));
        chk("nto_op", o_alu_op, 6'h03);
        exp_starts++;
        tick();
        finish_cmd(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
